vga_scan: RTL

- Parametrised successor to the fixed 640x480, 1-bit VGA scan-out block.
- Generates programmable H/V timing with selectable sync polarity.
- Issues framebuffer read addresses with power-of-two pixel replication and accepts 1 bpp or 8 bpp (RGB332) pixel data.
- Drives 8-bit colour, HS/VS pins and frame-level status (frame_start, vblank) for the ip/ram side. Runs in the pixel clock domain (vclk from the DCM).

---
 rtl/vga_scan.sv | 113 +++++++++++
 1 files changed

// File: rtl/vga_scan.sv
// Parametrised VGA scan-out: programmable H/V timing, framebuffer address generation with
// power-of-two pixel replication, 1 bpp or RGB332 pixel data, 3-cycle counter-to-pin latency.
module vga_scan #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned XW          = 9,
  parameter int unsigned YW          = 8,
  parameter int unsigned BPP         = 1
) (
  input  logic           clk,
  input  logic           rst,
  output logic [XW-1:0]  x_a,
  output logic [YW-1:0]  y_a,
  input  logic [BPP-1:0] in_a,
  input  logic [7:0]     fg,
  input  logic [7:0]     bg,
  output logic           HS,
  output logic           VS,
  output logic [2:0]     R,
  output logic [2:0]     G,
  output logic [1:0]     B,
  output logic           frame_start,
  output logic           vblank
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);

  if (BPP != 1 && BPP != 8) begin : g_bad_bpp
    $error("vga_scan: BPP must be 1 or 8");
  end

  logic [HCW-1:0] hcnt_q, hcnt_d, hsh;
  logic [VCW-1:0] vcnt_q, vcnt_d, vsh;
  logic           active0, hs0, vs0;
  logic           active_q1, hs_q1, vs_q1;
  logic           active_q2, hs_q2, vs_q2;
  logic [7:0]     colour;

  always_comb begin
    hcnt_d = hcnt_q + HCW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HCW'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VCW'(V_TOTAL - 1)) ? '0 : vcnt_q + VCW'(1);
    end
  end

  always_comb begin
    active0 = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    hs0     = (32'(hcnt_q) >= H_ACTIVE + H_FP) && (32'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC);
    vs0     = (32'(vcnt_q) >= V_ACTIVE + V_FP) && (32'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC);
    hsh     = hcnt_q >> SCALE_SHIFT;
    vsh     = vcnt_q >> SCALE_SHIFT;
  end

  // in_a is the RAM's registered read of the stage-1 address, so it lines up with stage 2.
  if (BPP == 1) begin : g_mono
    assign colour = in_a[0] ? fg : bg;
  end else begin : g_rgb
    logic unused_fg_bg;
    assign unused_fg_bg = ^{fg, bg};
    assign colour       = in_a[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      x_a         <= '0;
      y_a         <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      active_q1   <= 1'b0;
      hs_q1       <= 1'b0;
      vs_q1       <= 1'b0;
      active_q2   <= 1'b0;
      hs_q2       <= 1'b0;
      vs_q2       <= 1'b0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      {R, G, B}   <= 8'h00;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      x_a         <= active0 ? XW'(hsh) : '0;
      y_a         <= active0 ? YW'(vsh) : '0;
      frame_start <= (hcnt_q == '0) && (vcnt_q == '0);
      vblank      <= 32'(vcnt_q) >= V_ACTIVE;
      active_q1   <= active0;
      hs_q1       <= hs0;
      vs_q1       <= vs0;
      active_q2   <= active_q1;
      hs_q2       <= hs_q1;
      vs_q2       <= vs_q1;
      HS          <= hs_q2 ? HS_POL : ~HS_POL;
      VS          <= vs_q2 ? VS_POL : ~VS_POL;
      {R, G, B}   <= active_q2 ? colour : 8'h00;
    end
  end

endmodule
